div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin controller that shares one sequential divider peripheral between `N_REQ` hardware requesters. It sits between the requesters and the divider's register port and owns that port exclusively. It sequences each job as a dividend write, a divisor write, polling until the divider is idle, and reads of the quotient and remainder. It then returns the results to the granted requester with a one-cycle done pulse.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `POLL_LIMIT`, default 48: maximum POLL cycles before a job is aborted with error.

- `clk` in 1: sole clock.
- `rst` in 1: synchronous reset, active-high.
- `req` in N_REQ: per-requester request level.
- `req_dividend` in 32*N_REQ: flattened dividends; requester i uses bits [32i+31:32i].
- `req_divisor` in 32*N_REQ: flattened divisors, same packing.
- `done` out N_REQ: one-hot, one-cycle completion pulse.
- `err` out 1: one-cycle pulse coincident with `done` when the job timed out.
- `quotient` out 32: result of the last completed job, held until the next completion.
- `remainder` out 32: same, for the remainder.
- `arb_busy` out 1: high in every state except IDLE.
- `div_address` out 8: divider register address.
- `div_write_data` out 32: divider write data.
- `div_we` out 1: divider write strobe.
- `div_re` out 1: divider read strobe.
- `div_read_data` in 32: divider read data, combinational from `div_address`.

## Operation
- Divider offsets: 0x00 status (bit0 = busy), 0x04 dividend, 0x08 divisor (the write starts the divide), 0x0C quotient, 0x10 remainder.
- Reset values: `done`=0, `err`=0, `quotient`=0, `remainder`=0, `arb_busy`=0, `div_we`=0, `div_re`=1, `div_address`=0x00, `div_write_data`=0. The round-robin pointer is reset so requester 0 has top priority. State is IDLE.
- Outside WR_END/WR_SOR the block drives `div_we`=0 and `div_write_data`=0.
- States:
  - IDLE: drive address 0x00 with `div_re`=1. Grant only when at least one `req` bit is high and `div_read_data[0]`==0. The winner is the first requester with `req` high searching upward, wrapping, from (last granted + 1). Latch the winner index and its dividend and divisor, then go to WR_END.
  - WR_END: address 0x04, `div_we`=1, data = latched dividend; go to WR_SOR.
  - WR_SOR: address 0x08, `div_we`=1, data = latched divisor; clear the poll counter; go to POLL.
  - POLL: address 0x00, `div_re`=1. If bit0==0, go to RD_QUO. Otherwise increment the counter; when the counter reaches `POLL_LIMIT`, set the error flag, force captured results to 0, and go to DONE.
  - RD_QUO: address 0x0C; capture `div_read_data` into the quotient holding register; go to RD_REM.
  - RD_REM: address 0x10; capture into the remainder holding register; go to DONE.
  - DONE: update the `quotient` and `remainder` outputs; pulse `done[idx]`, and `err` if flagged; set the round-robin pointer to idx; go to IDLE.
- Requester handshake:
  - Hold `req` high until `done[i]`.
  - Operands are sampled only in the grant cycle.
  - Deassert `req` on the edge ending the `done` cycle. A `req` still high in the following IDLE cycle is a new job.
- Divide by zero is not special-cased: the divider returns quotient 0xFFFFFFFF and remainder = dividend, and these are passed through.
- The IDLE busy check is what prevents a write while the divider is still busy after `rst` mid-job. The divider is on its own reset, so it may still be busy.
- `rst` during any state: return to IDLE with the reset values on the next edge. No `done` pulse is issued for the aborted job.

## Timing
- Grant in cycle 0 (IDLE) → WR_END cycle 1 → WR_SOR cycle 2. The divider reports busy in cycles 3..34.
- POLL first sees bit0==0 in cycle 35 → RD_QUO 36 → RD_REM 37 → DONE 38 with `done` high.
- Job latency: 38 cycles from grant to `done`. Back-to-back jobs: the next grant is no earlier than cycle 39.
- Timeout fires on the POLL cycle where the counter equals `POLL_LIMIT`.

## Test plan
- Single job: `req[0]`, 100 / 7 → `done[0]` 38 cycles after grant; `quotient`=14, `remainder`=2, `err`=0.
- Contention: `req[0]` and `req[1]` asserted in the same cycle, both held → order is 0 then 1, then 0 again if reasserted; two `done` pulses 39 cycles apart. With the pointer at 1, the next simultaneous pair grants 0 first.
- Divide by zero: 0x12345678 / 0 → `quotient`=0xFFFFFFFF, `remainder`=0x12345678.
- Edge values: 0xFFFFFFFF / 1 → Q=0xFFFFFFFF, R=0; 5 / 9 → Q=0, R=5.
- Reset mid-POLL with the divider model still busy → no `done`. A new `req` is not granted until the divider status reads 0, then completes correctly.
- Divider model that never clears busy → `done` and `err` pulse together after `POLL_LIMIT` POLL cycles, with `quotient`=`remainder`=0.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Requester-side and divider-register-port signals of div_arbiter.
// master: the arbiter's view; slave: the requester/divider side.
interface div_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_dividend;
  logic [32*N_REQ-1:0] req_divisor;
  logic [N_REQ-1:0]    done;
  logic                err;
  logic [31:0]         quotient;
  logic [31:0]         remainder;
  logic                arb_busy;
  logic [7:0]          div_address;
  logic [31:0]         div_write_data;
  logic                div_we;
  logic                div_re;
  logic [31:0]         div_read_data;

  modport master (
    input  req, req_dividend, req_divisor, div_read_data,
    output done, err, quotient, remainder, arb_busy,
           div_address, div_write_data, div_we, div_re
  );

  modport slave (
    output req, req_dividend, req_divisor, div_read_data,
    input  done, err, quotient, remainder, arb_busy,
           div_address, div_write_data, div_we, div_re
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter that sequences divide jobs from N_REQ requesters onto
// a single sequential divider through its register port.
//
// state    | meaning
// IDLE     | poll divider status, grant next requester when divider is idle
// WR_END   | write latched dividend to offset 0x04
// WR_SOR   | write latched divisor to offset 0x08 (starts the divide)
// POLL     | read status until busy clears or the poll budget runs out
// RD_QUO   | read quotient (0x0C) into holding register
// RD_REM   | read remainder (0x10)
// DONE     | done/err pulse and results visible, round-robin pointer moves
module div_arbiter #(
  parameter int N_REQ      = 2,
  parameter int POLL_LIMIT = 48
) (
  input  logic          clk,
  input  logic          rst,
  div_arbiter_if.master io_bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(POLL_LIMIT + 1);

  localparam logic [7:0] A_STATUS    = 8'h00;
  localparam logic [7:0] A_DIVIDEND  = 8'h04;
  localparam logic [7:0] A_DIVISOR   = 8'h08;
  localparam logic [7:0] A_QUOTIENT  = 8'h0C;
  localparam logic [7:0] A_REMAINDER = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_END,
    S_WR_SOR,
    S_POLL,
    S_RD_QUO,
    S_RD_REM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_last;
  logic [31:0]        r_dividend;
  logic [31:0]        r_divisor;
  logic [31:0]        r_quo_hold;
  logic [CW-1:0]      r_poll_cnt;
  logic [N_REQ-1:0]   r_done;
  logic               r_err;
  logic [31:0]        r_quotient;
  logic [31:0]        r_remainder;

  logic [2*N_REQ-1:0] w_req2;
  logic [IW-1:0]      w_win;
  logic               w_found;
  logic [N_REQ-1:0]   w_onehot;
  logic [CW-1:0]      w_poll_inc;
  logic               w_div_busy;
  logic               w_timeout;
  logic [7:0]         w_addr;
  logic [31:0]        w_wdata;
  logic               w_we;
  logic               w_re;

  assign w_req2     = {io_bus.req, io_bus.req};
  assign w_div_busy = io_bus.div_read_data[0];
  assign w_poll_inc = r_poll_cnt + CW'(1);

  // Search upward from the requester after the last one granted, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && w_req2[int'(r_last) + k]) begin
        w_found = 1'b1;
        if (int'(r_last) + k >= N_REQ) begin
          w_win = IW'(int'(r_last) + k - N_REQ);
        end else begin
          w_win = IW'(int'(r_last) + k);
        end
      end
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  always_comb begin
    w_next    = r_state;
    w_addr    = A_STATUS;
    w_wdata   = '0;
    w_we      = 1'b0;
    w_re      = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_re = 1'b1;
        if (w_found && !w_div_busy) begin
          w_next = S_WR_END;
        end
      end
      S_WR_END: begin
        w_addr  = A_DIVIDEND;
        w_we    = 1'b1;
        w_wdata = r_dividend;
        w_next  = S_WR_SOR;
      end
      S_WR_SOR: begin
        w_addr  = A_DIVISOR;
        w_we    = 1'b1;
        w_wdata = r_divisor;
        w_next  = S_POLL;
      end
      S_POLL: begin
        w_re = 1'b1;
        if (!w_div_busy) begin
          w_next = S_RD_QUO;
        end else if (w_poll_inc == CW'(POLL_LIMIT)) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_RD_QUO: begin
        w_addr = A_QUOTIENT;
        w_re   = 1'b1;
        w_next = S_RD_REM;
      end
      S_RD_REM: begin
        w_addr = A_REMAINDER;
        w_re   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_last      <= IW'(N_REQ - 1);
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_quo_hold  <= '0;
      r_poll_cnt  <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= '0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_WR_END) begin
            r_idx      <= w_win;
            r_dividend <= io_bus.req_dividend[32*int'(w_win) +: 32];
            r_divisor  <= io_bus.req_divisor[32*int'(w_win) +: 32];
          end
        end
        S_WR_SOR: r_poll_cnt <= '0;
        S_POLL: begin
          if (w_div_busy) begin
            r_poll_cnt <= w_poll_inc;
          end
        end
        S_RD_QUO: r_quo_hold <= io_bus.div_read_data;
        S_DONE:   r_last     <= r_idx;
        default: ;
      endcase
      // Results and pulses are loaded on entry so they line up with the DONE cycle.
      if (w_next == S_DONE) begin
        r_done      <= w_onehot;
        r_err       <= w_timeout;
        r_quotient  <= w_timeout ? 32'h0 : r_quo_hold;
        r_remainder <= w_timeout ? 32'h0 : io_bus.div_read_data;
      end
    end
  end

  assign io_bus.done           = r_done;
  assign io_bus.err            = r_err;
  assign io_bus.quotient       = r_quotient;
  assign io_bus.remainder      = r_remainder;
  assign io_bus.arb_busy       = (r_state != S_IDLE);
  assign io_bus.div_address    = w_addr;
  assign io_bus.div_write_data = w_wdata;
  assign io_bus.div_we         = w_we;
  assign io_bus.div_re         = w_re;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider model, round-robin/arithmetic
// reference, directed and random jobs, reset mid-job and poll timeout.
module tb_div_arbiter;
  localparam int N  = 3;
  localparam int PL = 48;

  logic clk = 1'b0;
  logic rst;
  logic div_rst;
  always #5 clk = ~clk;

  div_arbiter_if #(.N_REQ(N)) io();

  div_arbiter #(.N_REQ(N), .POLL_LIMIT(PL)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(io)
  );

  // Divider model: 32 busy cycles after the divisor write, own reset.
  int          m_cnt;
  logic        m_stuck;
  logic        stuck_arm;
  logic        m_busy;
  logic        m_wr_busy_seen;
  logic [31:0] m_dvd, m_q, m_r;

  assign m_busy = (m_cnt != 0) || m_stuck;

  always @(posedge clk) begin
    if (div_rst) begin
      m_cnt   <= 0;
      m_stuck <= 1'b0;
      m_dvd   <= '0;
      m_q     <= '0;
      m_r     <= '0;
    end else begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (io.div_we) begin
        if (m_busy) m_wr_busy_seen <= 1'b1;
        if (io.div_address == 8'h04) begin
          m_dvd <= io.div_write_data;
        end else if (io.div_address == 8'h08) begin
          m_cnt   <= 32;
          m_stuck <= stuck_arm;
          if (io.div_write_data == 32'h0) begin
            m_q <= 32'hFFFF_FFFF;
            m_r <= m_dvd;
          end else begin
            m_q <= m_dvd / io.div_write_data;
            m_r <= m_dvd % io.div_write_data;
          end
        end
      end
    end
  end

  always_comb begin
    io.div_read_data = '0;
    case (io.div_address)
      8'h00:   io.div_read_data = {31'b0, m_busy};
      8'h0C:   io.div_read_data = m_q;
      8'h10:   io.div_read_data = m_r;
      default: io.div_read_data = '0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_g;
  logic [31:0]  op_a [N];
  logic [31:0]  op_b [N];
  logic [N-1:0] mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Raise all requests in msk together, hold each until its done pulse.
  task automatic serve(input logic [N-1:0] msk);
    logic [N-1:0] pend;
    int n;
    int idx;
    int iter;
    bit first;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      io.req_dividend[32*i +: 32] = op_a[i];
      io.req_divisor[32*i +: 32]  = op_b[i];
    end
    io.req = msk;
    pend   = msk;
    first  = 1'b1;
    iter   = 0;
    while (pend != 0 && iter < N + 2) begin
      iter++;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (first && n == 1) chk("busy_after_grant", 32'(io.arb_busy), 32'd1);
      end while (io.done == 0 && n < 400);
      chk("done_seen", 32'(io.done != 0), 32'd1);
      if (io.done == 0) begin
        pend = '0;
      end else begin
        idx = rr_pick(pend, last_g);
        chk("latency", n, first ? 38 : 39);
        chk("done_onehot", 32'(io.done), 32'(1) << idx);
        chk("err", 32'(io.err), 32'd0);
        chk("quotient", io.quotient, ref_q(op_a[idx], op_b[idx]));
        chk("remainder", io.remainder, ref_r(op_a[idx], op_b[idx]));
        io.req = io.req & ~io.done;
        pend   = pend & ~io.done;
        last_g = idx;
        first  = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse_width", 32'(io.done), 32'd0);
  endtask

  initial begin
    int n;
    int idle_at;
    rst             = 1'b1;
    div_rst         = 1'b1;
    stuck_arm       = 1'b0;
    m_wr_busy_seen  = 1'b0;
    io.req          = '0;
    io.req_dividend = '0;
    io.req_divisor  = '0;
    last_g          = N - 1;
    repeat (3) @(negedge clk);

    chk("rst_done", 32'(io.done), 32'd0);
    chk("rst_err", 32'(io.err), 32'd0);
    chk("rst_quotient", io.quotient, 32'd0);
    chk("rst_remainder", io.remainder, 32'd0);
    chk("rst_arb_busy", 32'(io.arb_busy), 32'd0);
    chk("rst_div_we", 32'(io.div_we), 32'd0);
    chk("rst_div_re", 32'(io.div_re), 32'd1);
    chk("rst_div_address", 32'(io.div_address), 32'd0);
    chk("rst_div_wdata", io.div_write_data, 32'd0);
    rst     = 1'b0;
    div_rst = 1'b0;

    // Contention from reset, then again with the pointer at 1.
    op_a[0] = 32'd1000; op_b[0] = 32'd10;
    op_a[1] = 32'd77;   op_b[1] = 32'd5;
    serve(3'b011);
    op_a[0] = 32'd999;  op_b[0] = 32'd4;
    op_a[1] = 32'd64;   op_b[1] = 32'd8;
    serve(3'b011);

    op_a[0] = 32'd100; op_b[0] = 32'd7;
    serve(3'b001);
    op_a[1] = 32'h1234_5678; op_b[1] = 32'd0;
    serve(3'b010);
    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'd1;
    serve(3'b100);
    op_a[0] = 32'd5; op_b[0] = 32'd9;
    serve(3'b001);

    for (int it = 0; it < 6; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        op_a[i] = $urandom;
        case ($urandom_range(0, 3))
          0:       op_b[i] = 32'd0;
          1:       op_b[i] = $urandom;
          default: op_b[i] = $urandom_range(1, 20);
        endcase
      end
      serve(mask);
    end

    // Reset mid-POLL: no done for the aborted job, new job waits for idle divider.
    @(negedge clk);
    io.req_dividend[31:0] = 32'd100;
    io.req_divisor[31:0]  = 32'd7;
    io.req = 3'b001;
    repeat (10) @(negedge clk);
    chk("busy_in_poll", 32'(io.arb_busy), 32'd1);
    rst    = 1'b1;
    io.req = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_idle", 32'(io.arb_busy), 32'd0);
    chk("rst_mid_no_done", 32'(io.done), 32'd0);
    last_g = N - 1;
    io.req_dividend[63:32] = 32'd5;
    io.req_divisor[63:32]  = 32'd9;
    io.req  = 3'b010;
    n       = 0;
    idle_at = -1;
    do begin
      @(negedge clk);
      n++;
      if (idle_at < 0 && !m_busy) idle_at = n;
    end while (io.done == 0 && n < 400);
    chk("resume_latency", n, idle_at + 38);
    chk("resume_done", 32'(io.done), 32'b010);
    chk("resume_quotient", io.quotient, 32'd0);
    chk("resume_remainder", io.remainder, 32'd5);
    io.req = '0;
    last_g = 1;
    @(negedge clk);

    // Divider that never clears busy after this job starts.
    stuck_arm = 1'b1;
    io.req_dividend[95:64] = 32'd10;
    io.req_divisor[95:64]  = 32'd3;
    io.req = 3'b100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (io.done == 0 && n < 400);
    chk("timeout_latency", n, 3 + PL);
    chk("timeout_done", 32'(io.done), 32'b100);
    chk("timeout_err", 32'(io.err), 32'd1);
    chk("timeout_quotient", io.quotient, 32'd0);
    chk("timeout_remainder", io.remainder, 32'd0);
    io.req = '0;
    @(negedge clk);
    chk("err_pulse_width", 32'(io.err), 32'd0);
    stuck_arm = 1'b0;
    div_rst   = 1'b1;
    @(negedge clk);
    div_rst = 1'b0;

    chk("no_write_while_busy", 32'(m_wr_busy_seen), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
